// File: rtl/alu_pkg.sv
// Shared widths for the ALU integer datapath.
// The adder is split into NUM_BLK lookahead slices of CLA_BLK_W bits each.
package alu_pkg;

  localparam int WORD_W    = 32;
  localparam int CLA_BLK_W = 4;
  localparam int NUM_BLK   = WORD_W / CLA_BLK_W;

endpackage

// File: rtl/cla_4.sv
// 4-bit carry-lookahead slice.
// Produces the sum bits plus group propagate/generate for the second lookahead level.
module cla_4
  import alu_pkg::*;
(
  input  logic [CLA_BLK_W-1:0] a,
  input  logic [CLA_BLK_W-1:0] b,
  input  logic                 c_in,
  output logic [CLA_BLK_W-1:0] s,
  output logic                 pg,
  output logic                 gg
);

  logic [CLA_BLK_W-1:0] p;
  logic [CLA_BLK_W-1:0] g;
  logic [CLA_BLK_W-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every internal carry is a flat sum of products, with no ripple between bits.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);

  assign s  = p ^ c;
  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/adder_32.sv
// 32-bit two-level carry-lookahead adder with a registered sum and carry out.
// Eight cla_4 slices feed a second-level lookahead that computes every slice carry directly.
module adder_32
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c_in,
  output logic [WORD_W-1:0] s,
  output logic              c_out
);

  logic [NUM_BLK-1:0] blk_pg;
  logic [NUM_BLK-1:0] blk_gg;
  logic [NUM_BLK:0]   blk_c;
  logic [WORD_W-1:0]  sum;

  for (genvar i = 0; i < NUM_BLK; i++) begin : g_slice
    cla_4 u_cla (
      .a    (a[i*CLA_BLK_W +: CLA_BLK_W]),
      .b    (b[i*CLA_BLK_W +: CLA_BLK_W]),
      .c_in (blk_c[i]),
      .s    (sum[i*CLA_BLK_W +: CLA_BLK_W]),
      .pg   (blk_pg[i]),
      .gg   (blk_gg[i])
    );
  end

  // Slice carry i is the OR of each lower generate masked by the propagates above it,
  // plus c_in masked by all lower propagates, so no carry waits on another slice's carry.
  always_comb begin
    logic acc;
    logic term;
    blk_c    = '0;
    acc      = 1'b0;
    term     = 1'b0;
    blk_c[0] = c_in;
    for (int i = 1; i <= NUM_BLK; i++) begin
      term = c_in;
      for (int k = 0; k < i; k++) begin
        term = term & blk_pg[k];
      end
      acc = term;
      for (int j = 0; j < i; j++) begin
        term = blk_gg[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & blk_pg[k];
        end
        acc = acc | term;
      end
      blk_c[i] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= '0;
      c_out <= 1'b0;
    end else begin
      s     <= sum;
      c_out <= blk_c[NUM_BLK];
    end
  end

endmodule

// File: tb/tb_adder_32.sv
// Scoreboard bench for adder_32: each driven cycle queues its 33-bit expected result,
// which is popped and compared on the following cycle.
module tb_adder_32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic [31:0] s;
  logic        c_out;

  logic [32:0] exp_q[$];
  string       tag_q[$];
  int          assert_cnt;
  int          fail_cnt;

  adder_32 dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .s     (s),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [32:0] got, input logic [32:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got c_out=%b s=%h, expected c_out=%b s=%h",
               tag, got[32], got[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Outputs are stable at the falling edge; check the previous cycle, then drive the next one.
  task automatic retireOne();
    logic [32:0] exp;
    string       tag;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      checkOutput(tag, {c_out, s}, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic [31:0] av,
                               input logic [31:0] bv, input logic cv);
    logic [32:0] exp;
    @(negedge clk);
    retireOne();
    rst  = r;
    a    = av;
    b    = bv;
    c_in = cv;
    exp  = r ? 33'd0 : ({1'b0, av} + {1'b0, bv} + {32'd0, cv});
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    rst  = 1'b1;
    a    = '0;
    b    = '0;
    c_in = 1'b0;

    applyStimulus("reset0", 1'b1, 32'd5, 32'd7, 1'b0);
    applyStimulus("reset1", 1'b1, 32'd5, 32'd7, 1'b0);
    applyStimulus("post_reset", 1'b0, 32'd5, 32'd7, 1'b0);

    applyStimulus("add_1_2", 1'b0, 32'd1, 32'd2, 1'b0);
    applyStimulus("add_100_200_1", 1'b0, 32'd100, 32'd200, 1'b1);
    applyStimulus("full_prop", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    applyStimulus("half_prop", 1'b0, 32'h0000_FFFF, 32'h1, 1'b0);
    applyStimulus("max_max_1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("msb_msb", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus("zero", 1'b0, 32'h0, 32'h0, 1'b0);

    applyStimulus("pipe0", 1'b0, 32'd10, 32'd20, 1'b0);
    applyStimulus("pipe1", 1'b0, 32'd7, 32'd8, 1'b1);
    applyStimulus("pipe2", 1'b0, 32'd2147483647, 32'd1, 1'b0);

    // A reset edge in mid-stream must discard the operands present at that edge.
    applyStimulus("mid_reset", 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    applyStimulus("after_reset", 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);

    // Slice-boundary carries: a single propagate run ending at each slice edge.
    for (int i = 0; i < 8; i++) begin
      applyStimulus("slice_edge", 1'b0, (32'h1 << (4 * i + 4)) - 32'h1, 32'h0, 1'b1);
    end

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 0) rb = ~ra;
      applyStimulus("random", 1'b0, ra, rb, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    retireOne();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
